// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions between the operand stage and the ALU:
//   - RV32I opcodes handled by the integer ALU path (OP, OP-IMM)
//   - fct3 codes for the ALU operations
//   - op_fields_t : the bundle of control fields and operands handed to the ALU
//   - decode_op() : builds op_fields_t from an instruction word and the two
//                   register read values
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SLL  = 3'b001;
  localparam logic [2:0] SLT  = 3'b010;
  localparam logic [2:0] SLTU = 3'b011;
  localparam logic [2:0] XOR  = 3'b100;
  localparam logic [2:0] SRX  = 3'b101;  // SRL/SRA, selected by fct7[5]
  localparam logic [2:0] OR   = 3'b110;
  localparam logic [2:0] AND  = 3'b111;

  typedef struct packed {
    logic        rcc;      // 1 = register/register form (second operand from rs2)
    logic [2:0]  fct3;
    logic [6:0]  fct7;
    logic [31:0] rs1;
    logic [31:0] s2;       // signed view of the second operand
    logic [31:0] u2;       // unsigned view of the second operand
    logic [4:0]  rd;
    logic        illegal;
  } op_fields_t;

  // Unsupported opcodes yield an all-zero bundle with only illegal set, so the
  // ALU never sees stale operands for an instruction it must not execute.
  function automatic op_fields_t decode_op(input logic [31:0] insn,
                                           input logic [31:0] rs1_data,
                                           input logic [31:0] rs2_data);
    op_fields_t f;
    logic [11:0] imm;
    f   = '0;
    imm = insn[31:20];
    if (insn[6:0] == OPC_OP) begin
      f.rcc  = 1'b1;
      f.s2   = rs2_data;
      f.u2   = rs2_data;
    end else if (insn[6:0] == OPC_OPIMM) begin
      f.s2   = {{20{imm[11]}}, imm};
      f.u2   = {20'd0, imm};
    end else begin
      f.illegal = 1'b1;
    end
    if (!f.illegal) begin
      f.fct3 = insn[14:12];
      f.fct7 = insn[31:25];
      f.rs1  = rs1_data;
      f.rd   = insn[11:7];
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// 32 x 32-bit integer register file, x0 hard-wired to zero.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset (clears x1..x31)
//   rd_addr_a / rd_data_a  : read port A (combinational)
//   rd_addr_b / rd_data_b  : read port B (combinational)
//   wr_en/wr_addr/wr_data  : write port, visible to reads from the next cycle
// BYPASS=1 forwards a same-cycle write to matching reads.
// -----------------------------------------------------------------------------
module alu_regfile #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] rf_word [32];

  // Every register is reset, so the file is built from individual flops
  // rather than a RAM macro.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_word[gi] = '0;
      end else begin : g_word
        logic [31:0] word_reg;
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            word_reg <= '0;
          end else if (wr_en && (wr_addr == 5'(gi))) begin
            word_reg <= wr_data;
          end
        end
        assign rf_word[gi] = word_reg;
      end
    end
  endgenerate

  logic hit_a;
  logic hit_b;

  assign hit_a = (BYPASS != 1'b0) && wr_en && (wr_addr == rd_addr_a);
  assign hit_b = (BYPASS != 1'b0) && wr_en && (wr_addr == rd_addr_b);

  // x0 check comes first so a write-back aimed at x0 is never forwarded.
  assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 :
                     hit_a               ? wr_data : rf_word[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 :
                     hit_b               ? wr_data : rf_word[rd_addr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
// Decode/operand-fetch stage in front of the integer ALU. Accepts one RV32I
// instruction per handshake, reads rs1/rs2 from the register file, and
// presents registered control fields and operands one cycle later.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid/in_ready/in_insn  : instruction input handshake
//   flush                      : drop held operation and block acceptance
//   wb_en/wb_rd/wb_data        : register-file write-back
//   out_valid/out_ready        : ALU-side handshake
//   out_rcc/out_fct3/out_fct7  : ALU control fields
//   out_rs1/out_s2/out_u2      : operands (second operand signed/unsigned)
//   out_rd, out_illegal        : destination register, unsupported opcode
//   issued_cnt                 : wrapping count of delivered operations
// -----------------------------------------------------------------------------
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_rcc,
  output logic [2:0]       out_fct3,
  output logic [6:0]       out_fct7,
  output logic [31:0]      out_rs1,
  output logic [31:0]      out_s2,
  output logic [31:0]      out_u2,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  op_fields_t  dec_next;
  op_fields_t  op_reg;
  logic        valid_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic        accept;

  alu_regfile #(
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (in_insn[19:15]),
    .rd_data_a (rs1_data),
    .rd_addr_b (in_insn[24:20]),
    .rd_data_b (rs2_data),
    .wr_en     (wb_en),
    .wr_addr   (wb_rd),
    .wr_data   (wb_data)
  );

  assign dec_next = decode_op(in_insn, rs1_data, rs2_data);

  // in_ready deliberately ignores flush; flush only suppresses the capture.
  assign in_ready = rst_n & (~valid_reg | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      op_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      if (valid_reg && out_ready) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (accept) begin
        // Operands are frozen here; later write-backs cannot reach op_reg.
        valid_reg <= 1'b1;
        op_reg    <= dec_next;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_reg;
  assign out_rcc     = op_reg.rcc;
  assign out_fct3    = op_reg.fct3;
  assign out_fct7    = op_reg.fct7;
  assign out_rs1     = op_reg.rs1;
  assign out_s2      = op_reg.s2;
  assign out_u2      = op_reg.u2;
  assign out_rd      = op_reg.rd;
  assign out_illegal = op_reg.illegal;
  assign issued_cnt  = cnt_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed bench. Two instances share all inputs: dut (BYPASS=1, CNT_W=4, to
// reach the counter wrap quickly) and dut_nb (BYPASS=0, CNT_W=32).
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_insn = 32'd0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_rcc, out_illegal;
  logic [2:0]  out_fct3;
  logic [6:0]  out_fct7;
  logic [31:0] out_rs1, out_s2, out_u2;
  logic [4:0]  out_rd;
  logic [3:0]  issued_cnt;

  logic        nb_in_ready, nb_out_valid, nb_out_rcc, nb_out_illegal;
  logic [2:0]  nb_out_fct3;
  logic [6:0]  nb_out_fct7;
  logic [31:0] nb_out_rs1, nb_out_s2, nb_out_u2;
  logic [4:0]  nb_out_rd;
  logic [31:0] nb_issued_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  localparam logic [31:0] INSN_ADD  = 32'h006283B3; // add  x7,x5,x6
  localparam logic [31:0] INSN_SRAI = 32'h40315093; // srai x1,x2,3
  localparam logic [31:0] INSN_ADDI = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] INSN_RD3  = 32'h00018433; // add  x8,x3,x0
  localparam logic [31:0] INSN_RD0  = 32'h000004B3; // add  x9,x0,x0
  localparam logic [31:0] INSN_RD10 = 32'h000505B3; // add  x11,x10,x0

  always #5 clk = ~clk;

  alu_operand_stage #(.BYPASS(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_rcc(out_rcc), .out_fct3(out_fct3), .out_fct7(out_fct7),
    .out_rs1(out_rs1), .out_s2(out_s2), .out_u2(out_u2), .out_rd(out_rd),
    .out_illegal(out_illegal), .issued_cnt(issued_cnt)
  );

  alu_operand_stage #(.BYPASS(1'b0), .CNT_W(32)) dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nb_in_ready),
    .in_insn(in_insn), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(nb_out_valid), .out_ready(out_ready),
    .out_rcc(nb_out_rcc), .out_fct3(nb_out_fct3), .out_fct7(nb_out_fct7),
    .out_rs1(nb_out_rs1), .out_s2(nb_out_s2), .out_u2(nb_out_u2), .out_rd(nb_out_rd),
    .out_illegal(nb_out_illegal), .issued_cnt(nb_issued_cnt)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD;
    in_valid = 1'b1; in_insn = INSN_ADD; out_ready = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (issued_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", issued_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (nb_in_ready !== 1'b0) begin errors++; $display("FAIL reset_nb_in_ready: got %b expected 0", nb_in_ready); end
    checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", out_rd); end
    rst_n = 1'b1; wb_en = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready: got %b expected 1", in_ready); end
    step();
    $display("test_reset: first accept add x7,x5,x6 rs1=%h rd=%0d", out_rs1, out_rd);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_accept_valid: got %b expected 1", out_valid); end
    checks++; if (out_rs1 !== 32'd0) begin errors++; $display("FAIL reset_wb_ignored: got %h expected 0", out_rs1); end
    checks++; if (out_rd !== 5'd7) begin errors++; $display("FAIL first_rd: got %0d expected 7", out_rd); end
    checks++; if (out_rcc !== 1'b1) begin errors++; $display("FAIL first_rcc: got %b expected 1", out_rcc); end
    in_valid = 1'b0;
    step(); exp_cnt++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    checks++; if (issued_cnt !== exp_cnt[3:0]) begin errors++; $display("FAIL cnt_after_first: got %0d expected %0d", issued_cnt, exp_cnt[3:0]); end
  endtask

  task automatic test_add();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_0010; step();
    wb_rd = 5'd6; wb_data = 32'hFFFF_FFF0; step();
    wb_en = 1'b0; in_valid = 1'b1; in_insn = INSN_ADD; step();
    $display("test_add: add x7,x5,x6 rs1=%h s2=%h u2=%h", out_rs1, out_s2, out_u2);
    checks++; if (out_rcc !== 1'b1) begin errors++; $display("FAIL add_rcc: got %b expected 1", out_rcc); end
    checks++; if (out_rs1 !== 32'h10) begin errors++; $display("FAIL add_rs1: got %h expected 00000010", out_rs1); end
    checks++; if (out_s2 !== 32'hFFFF_FFF0) begin errors++; $display("FAIL add_s2: got %h expected fffffff0", out_s2); end
    checks++; if (out_u2 !== 32'hFFFF_FFF0) begin errors++; $display("FAIL add_u2: got %h expected fffffff0", out_u2); end
    checks++; if (out_rd !== 5'd7) begin errors++; $display("FAIL add_rd: got %0d expected 7", out_rd); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL add_illegal: got %b expected 0", out_illegal); end
    in_valid = 1'b0; step(); exp_cnt++;
    checks++; if (issued_cnt !== exp_cnt[3:0]) begin errors++; $display("FAIL add_cnt: got %0d expected %0d", issued_cnt, exp_cnt[3:0]); end
  endtask

  task automatic test_imm();
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h8000_0000; step();
    wb_en = 1'b0; in_valid = 1'b1; in_insn = INSN_SRAI; step();
    $display("test_imm: srai x1,x2,3 fct3=%0d fct7=%h s2=%h", out_fct3, out_fct7, out_s2);
    checks++; if (out_fct3 !== 3'd5) begin errors++; $display("FAIL srai_fct3: got %0d expected 5", out_fct3); end
    checks++; if (out_fct7 !== 7'h20) begin errors++; $display("FAIL srai_fct7: got %h expected 20", out_fct7); end
    checks++; if (out_u2[4:0] !== 5'd3) begin errors++; $display("FAIL srai_shamt: got %0d expected 3", out_u2[4:0]); end
    checks++; if (out_s2 !== 32'h0000_0403) begin errors++; $display("FAIL srai_s2: got %h expected 00000403", out_s2); end
    checks++; if (out_rs1 !== 32'h8000_0000) begin errors++; $display("FAIL srai_rs1: got %h expected 80000000", out_rs1); end
    checks++; if (out_rcc !== 1'b0) begin errors++; $display("FAIL srai_rcc: got %b expected 0", out_rcc); end
    checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL srai_rd: got %0d expected 1", out_rd); end
    in_insn = INSN_ADDI; step(); exp_cnt++;
    $display("test_imm: addi x1,x0,-1 s2=%h u2=%h", out_s2, out_u2);
    checks++; if (out_s2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_s2: got %h expected ffffffff", out_s2); end
    checks++; if (out_u2 !== 32'h0000_0FFF) begin errors++; $display("FAIL addi_u2: got %h expected 00000fff", out_u2); end
    checks++; if (out_fct7 !== 7'h7F) begin errors++; $display("FAIL addi_fct7: got %h expected 7f", out_fct7); end
    checks++; if (out_rs1 !== 32'd0) begin errors++; $display("FAIL addi_rs1: got %h expected 0", out_rs1); end
    in_valid = 1'b0; step(); exp_cnt++;
    checks++; if (issued_cnt !== exp_cnt[3:0]) begin errors++; $display("FAIL imm_cnt: got %0d expected %0d", issued_cnt, exp_cnt[3:0]); end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234; in_valid = 1'b1; in_insn = INSN_RD3;
    step();
    $display("test_bypass: same-cycle wb x3 rs1 bypass=%h no_bypass=%h", out_rs1, nb_out_rs1);
    checks++; if (out_rs1 !== 32'h1234) begin errors++; $display("FAIL bypass_rs1: got %h expected 00001234", out_rs1); end
    checks++; if (nb_out_rs1 !== 32'd0) begin errors++; $display("FAIL nobypass_rs1: got %h expected 0", nb_out_rs1); end
    wb_en = 1'b0; step(); exp_cnt++;
    $display("test_bypass: next-cycle read x3 rs1 bypass=%h no_bypass=%h", out_rs1, nb_out_rs1);
    checks++; if (nb_out_rs1 !== 32'h1234) begin errors++; $display("FAIL nobypass_next_rs1: got %h expected 00001234", nb_out_rs1); end
    checks++; if (out_rs1 !== 32'h1234) begin errors++; $display("FAIL bypass_next_rs1: got %h expected 00001234", out_rs1); end
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; in_insn = INSN_RD0;
    step(); exp_cnt++;
    $display("test_bypass: wb x0 same cycle rs1=%h s2=%h", out_rs1, out_s2);
    checks++; if (out_rs1 !== 32'd0) begin errors++; $display("FAIL x0_bypass_rs1: got %h expected 0", out_rs1); end
    checks++; if (out_s2 !== 32'd0) begin errors++; $display("FAIL x0_bypass_s2: got %h expected 0", out_s2); end
    wb_en = 1'b0; step(); exp_cnt++;
    checks++; if (out_rs1 !== 32'd0) begin errors++; $display("FAIL x0_after_wb: got %h expected 0", out_rs1); end
    checks++; if (nb_out_rs1 !== 32'd0) begin errors++; $display("FAIL nb_x0_after_wb: got %h expected 0", nb_out_rs1); end
    in_valid = 1'b0; step(); exp_cnt++;
    checks++; if (nb_issued_cnt !== exp_cnt) begin errors++; $display("FAIL bypass_cnt: got %0d expected %0d", nb_issued_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_insn = INSN_ADD; out_ready = 1'b1; step();
    out_ready = 1'b0; in_insn = INSN_ADDI; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step(); wb_en = 1'b0;
      $display("test_back_to_back: stall cycle %0d rs1=%h rd=%0d cnt=%0d", i, out_rs1, out_rd, issued_cnt);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_rs1 !== 32'h10) begin errors++; $display("FAIL stall_rs1[%0d]: got %h expected 00000010", i, out_rs1); end
      checks++; if (out_s2 !== 32'hFFFF_FFF0) begin errors++; $display("FAIL stall_s2[%0d]: got %h expected fffffff0", i, out_s2); end
      checks++; if (out_rd !== 5'd7) begin errors++; $display("FAIL stall_rd[%0d]: got %0d expected 7", i, out_rd); end
      checks++; if (issued_cnt !== exp_cnt[3:0]) begin errors++; $display("FAIL stall_cnt[%0d]: got %0d expected %0d", i, issued_cnt, exp_cnt[3:0]); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    step(); exp_cnt++;
    $display("test_back_to_back: released, next op rd=%0d s2=%h cnt=%0d", out_rd, out_s2, issued_cnt);
    checks++; if (issued_cnt !== exp_cnt[3:0]) begin errors++; $display("FAIL release_cnt: got %0d expected %0d", issued_cnt, exp_cnt[3:0]); end
    checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL release_rd: got %0d expected 1", out_rd); end
    checks++; if (out_s2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL release_s2: got %h expected ffffffff", out_s2); end
    in_valid = 1'b0; step(); exp_cnt++;
  endtask

  task automatic test_flush();
    flush = 1'b1; in_valid = 1'b1; in_insn = INSN_ADD;
    wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'hABC;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    step();
    $display("test_flush: flush with in_valid valid=%b cnt=%0d", out_valid, issued_cnt);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_block: got %b expected 0", out_valid); end
    checks++; if (issued_cnt !== exp_cnt[3:0]) begin errors++; $display("FAIL flush_cnt: got %0d expected %0d", issued_cnt, exp_cnt[3:0]); end
    flush = 1'b0; wb_en = 1'b0; in_insn = 32'h0000_006F; step();
    $display("test_flush: jal illegal=%b rs1=%h s2=%h", out_illegal, out_rs1, out_s2);
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL jal_illegal: got %b expected 1", out_illegal); end
    checks++; if ({out_rs1, out_s2, out_u2} !== 96'd0) begin errors++; $display("FAIL jal_operands: got %h expected 0", {out_rs1, out_s2, out_u2}); end
    checks++; if (out_rcc !== 1'b0) begin errors++; $display("FAIL jal_rcc: got %b expected 0", out_rcc); end
    in_insn = 32'hFFFF_FFFF; step(); exp_cnt++;
    $display("test_flush: opcode 7f illegal=%b fct3=%0d fct7=%h rd=%0d", out_illegal, out_fct3, out_fct7, out_rd);
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ones_illegal: got %b expected 1", out_illegal); end
    checks++; if ({out_fct3, out_fct7, out_rd} !== 15'd0) begin errors++; $display("FAIL ones_fields: got %h expected 0", {out_fct3, out_fct7, out_rd}); end
    checks++; if ({out_s2, out_u2} !== 64'd0) begin errors++; $display("FAIL ones_operands: got %h expected 0", {out_s2, out_u2}); end
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b0; step();
    $display("test_flush: flush held op valid=%b cnt=%0d", out_valid, issued_cnt);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held: got %b expected 0", out_valid); end
    checks++; if (issued_cnt !== exp_cnt[3:0]) begin errors++; $display("FAIL flush_held_cnt: got %0d expected %0d", issued_cnt, exp_cnt[3:0]); end
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_insn = INSN_RD10; step();
    $display("test_flush: read x10 written during flush rs1=%h", out_rs1);
    checks++; if (out_rs1 !== 32'hABC) begin errors++; $display("FAIL flush_wb: got %h expected 00000abc", out_rs1); end
    checks++; if (out_rd !== 5'd11) begin errors++; $display("FAIL flush_wb_rd: got %0d expected 11", out_rd); end
    in_valid = 1'b0; step(); exp_cnt++;
  endtask

  task automatic test_wrap_reset();
    logic [4:0] r5;
    in_valid = 1'b1; in_insn = INSN_ADD; out_ready = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      step(); exp_cnt++;
    end
    $display("test_wrap_reset: cnt=%0d nb_cnt=%0d", issued_cnt, nb_issued_cnt);
    checks++; if (issued_cnt !== 4'd15) begin errors++; $display("FAIL pre_wrap_cnt: got %0d expected 15", issued_cnt); end
    step(); exp_cnt++;
    checks++; if (issued_cnt !== 4'd0) begin errors++; $display("FAIL wrap_cnt: got %0d expected 0", issued_cnt); end
    checks++; if (nb_issued_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_nb_cnt: got %0d expected %0d", nb_issued_cnt, exp_cnt); end
    step(); exp_cnt++;
    out_ready = 1'b0; rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    step(); exp_cnt = 0;
    $display("test_wrap_reset: reset while held valid=%b cnt=%0d", out_valid, issued_cnt);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if ({out_rs1, out_s2, out_u2} !== 96'd0) begin errors++; $display("FAIL rst_operands: got %h expected 0", {out_rs1, out_s2, out_u2}); end
    checks++; if ({out_rcc, out_fct3, out_fct7, out_rd, out_illegal} !== 17'd0) begin errors++; $display("FAIL rst_fields: got %h expected 0", {out_rcc, out_fct3, out_fct7, out_rd, out_illegal}); end
    checks++; if (issued_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", issued_cnt); end
    checks++; if (nb_issued_cnt !== 32'd0) begin errors++; $display("FAIL rst_nb_cnt: got %0d expected 0", nb_issued_cnt); end
    out_ready = 1'b1; step();
    checks++; if (issued_cnt !== 4'd0) begin errors++; $display("FAIL rst_no_deliver: got %0d expected 0", issued_cnt); end
    rst_n = 1'b1;
    for (int r = 1; r < 32; r++) begin
      r5 = r[4:0];
      in_insn = {7'd0, r5, r5, 3'd0, 5'd1, 7'h33};
      step();
      checks++; if (out_rs1 !== 32'd0 || out_s2 !== 32'd0) begin errors++; $display("FAIL rst_reg_x%0d: got rs1=%h s2=%h expected 0", r, out_rs1, out_s2); end
    end
    $display("test_wrap_reset: x1..x31 read after reset");
    in_valid = 1'b0; step();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_imm();
    test_bypass();
    test_back_to_back();
    test_flush();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: BYPASS, 1, 1 = forward same-cycle write-back data to register reads; 0 = no forwarding.
REQ-002 Parameter: CNT_W, 32, width of the issued-operation counter.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port: in_valid  in  1  instruction word present.
REQ-006 Port: in_ready  out  1  stage can accept.
REQ-007 Port: in_insn  in  32  RV32I instruction word.
REQ-008 Port: flush  in  1  discard the held and incoming operation.
REQ-009 Port: wb_en / wb_rd / wb_data  in  1/5/32  register-file write port.
REQ-010 Port: out_valid  out  1  operands valid for the ALU.
REQ-011 Port: out_ready  in  1  ALU side consumes.
REQ-012 Port: out_rcc, out_fct3, out_fct7  out  1/3/7  ALU control fields.
REQ-013 Port: out_rs1, out_s2, out_u2  out  32 each  ALU operands: signed and unsigned second operand.
REQ-014 Port: out_rd  out  5  destination register.
REQ-015 Port: out_illegal  out  1  opcode is not OP or OP-IMM.
REQ-016 Port: issued_cnt  out  CNT_W  count of operations handed to the ALU.

Function
REQ-017 in_ready SHALL equal rst_n & (!out_valid | out_ready); handshake only when in_valid & in_ready.
REQ-018 An accepted instruction SHALL appear on the outputs with out_valid=1 exactly one cycle after acceptance.
REQ-019 While out_valid & !out_ready, all out_* SHALL hold stable.
REQ-020 Opcode 0110011 (OP) SHALL give rcc=1, s2=u2=reg[insn[24:20]].
REQ-021 Opcode 0010011 (OP-IMM) SHALL give rcc=0, s2=sign-extended insn[31:20], u2=zero-extended insn[31:20].
REQ-022 For both legal opcodes: fct3=insn[14:12], fct7=insn[31:25], rs1=reg[insn[19:15]], rd=insn[11:7].
REQ-023 Any other opcode SHALL still be accepted with illegal=1, rcc=0, fct3=0, fct7=0, all operands 0, rd=0.
REQ-024 Register file: 32x32; x0 reads 0 always; writes to x0 are ignored; a write becomes visible to reads in the next cycle.
REQ-025 With BYPASS=1, a read of r (r!=0) SHALL return wb_data when wb_en & wb_rd==r in the same cycle.
REQ-026 Operands SHALL be captured at acceptance; later write-backs SHALL NOT alter a held output.
REQ-027 flush SHALL clear out_valid on the next edge and SHALL block the same-cycle acceptance; in_ready is unaffected by flush.
REQ-028 flush has priority over acceptance; write-back still occurs during flush.
REQ-029 issued_cnt SHALL increment on every out_valid & out_ready cycle, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-030 Asserting rst_n=0 on an edge SHALL set out_valid=0, all out_* data=0, issued_cnt=0, and all registers x1..x31=0.
REQ-031 While rst_n=0, in_ready=0 and write-back is ignored; a held operation is dropped by reset, not delivered.
REQ-032 The first acceptance SHALL be possible on the first edge with rst_n=1.

Structure
REQ-033 Shared package alu_pkg SHALL hold the opcode constants OPC_OP and OPC_OPIMM plus the fct3 codes ADD, SLL, SLT, SLTU, XOR, SRX, OR, AND, shared with the ALU.
REQ-034 The register file SHALL be a sub-module alu_regfile with 2 read ports, 1 write port, and a BYPASS parameter.

Verification
REQ-035 Write-back of x5=0x0000_0010 and x6=0xFFFF_FFF0, then issue `add x7,x5,x6` (0x006283B3) -> next cycle: rcc=1, rs1=0x10, s2=u2=0xFFFF_FFF0, rd=7.
REQ-036 `srai x1,x2,3` (0x40315093) with x2=0x8000_0000 -> fct3=5, fct7=0x20, u2[4:0]=3, s2=0x0000_0403, rcc=0.
REQ-037 Same-cycle wb x3=0x1234 with issue reading x3 -> rs1=0x1234 when BYPASS=1 and old value when BYPASS=0; read of x0 after wb_rd=0 -> 0.
REQ-038 Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, issued_cnt unchanged; then out_ready=1 -> one increment, next instruction accepted.
REQ-039 flush together with in_valid -> out_valid=0 next cycle, no increment; insn 0x0000006F (JAL) -> illegal=1, operands 0.
REQ-040 Assert rst_n=0 while out_valid=1 and issued_cnt preset near wrap (CNT_W=4, count 15 -> next 0) -> after reset all outputs 0, x1..x31 read 0.
